pulse_train_gen: RTL and testbench

Parameterised pulse-train generator for the stepper/driver timing path. It produces a programmable period/high-time pulse stream in continuous, burst-of-N or single-shot mode. Start/stop control, busy/done status, a completed-pulse counter and configuration error detection are included. It replaces the fixed-constant divider/N-pulse logic and is driven by the control FSM or the button front-end.

---
 rtl/pulse_train_gen.sv | 98 +++++++++
 tb/tb_pulse_train_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: programmable period/high-time pulse train with continuous, burst and single-shot modes.
module pulse_train_gen #(
    parameter int   CNT_W      = 16,
    parameter int   NUM_W      = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_time,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx,
    output logic             cfg_err
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] period_q, high_q, ph_q;
    logic [NUM_W-1:0] count_q, idx_q;
    logic             counted_q, stop_q, pulse_q, busy_q, done_q, cfg_err_q;
    logic             cfg_bad, wrap, finish;
    logic [CNT_W-1:0] ph_d;
    logic [NUM_W-1:0] idx_d;

    always_comb begin
        cfg_bad = period < CNT_W'(2) || high_time == '0 || high_time >= period ||
                  mode == 2'd3 || (mode == 2'd1 && num_pulses == '0);
        wrap    = ph_q == period_q - CNT_W'(1);
        ph_d    = wrap ? '0 : ph_q + CNT_W'(1);
        idx_d   = idx_q + NUM_W'(1);
        // a stop seen on the wrap edge itself ends the train there, same as a pending one
        finish  = wrap && ((counted_q && idx_d == count_q) || stop_q || stop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            period_q  <= '0;
            high_q    <= '0;
            ph_q      <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            counted_q <= 1'b0;
            stop_q    <= 1'b0;
            pulse_q   <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && !stop) begin
                    if (cfg_bad) begin
                        cfg_err_q <= 1'b1;
                    end else begin
                        state_q   <= RUN;
                        period_q  <= period;
                        high_q    <= high_time;
                        counted_q <= mode != 2'd0;
                        count_q   <= mode == 2'd1 ? num_pulses : NUM_W'(1);
                        ph_q      <= '0;
                        idx_q     <= '0;
                        stop_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        pulse_q   <= ~IDLE_LEVEL;
                    end
                end
            end else begin
                ph_q <= ph_d;
                if (stop) stop_q <= 1'b1;
                if (wrap) idx_q <= idx_d;
                if (finish) begin
                    state_q <= IDLE;
                    ph_q    <= '0;
                    stop_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pulse_q <= IDLE_LEVEL;
                end else begin
                    pulse_q <= ph_d < high_q ? ~IDLE_LEVEL : IDLE_LEVEL;
                end
            end
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_idx = idx_q;
    assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed stimulus with a queue of expected train/error events checked by a monitor.
module tb_pulse_train_gen;
    localparam int CW = 16;
    localparam int NW = 16;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, start1 = 1'b0;
    logic [1:0]    mode = '0;
    logic [CW-1:0] period = '0, high_time = '0;
    logic [NW-1:0] num_pulses = '0;
    logic          pulse_out, busy, done, cfg_err;
    logic          pulse_out1, busy1, done1, cfg_err1;
    logic [NW-1:0] pulse_idx, pulse_idx1;

    pulse_train_gen #(.CNT_W(CW), .NUM_W(NW), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .period(period),
        .high_time(high_time), .num_pulses(num_pulses), .pulse_out(pulse_out), .busy(busy),
        .done(done), .pulse_idx(pulse_idx), .cfg_err(cfg_err));

    pulse_train_gen #(.CNT_W(CW), .NUM_W(NW), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop), .mode(mode), .period(period),
        .high_time(high_time), .num_pulses(num_pulses), .pulse_out(pulse_out1), .busy(busy1),
        .done(done1), .pulse_idx(pulse_idx1), .cfg_err(cfg_err1));

    always #5 clk = ~clk;

    typedef struct {
        bit err;
        int busy_len;
        int act;
        int runs;
        int max_run;
        int idx;
    } exp_t;

    exp_t       q[$];
    logic [1:0] q1[$];
    int         compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] m, input int p, input int h, input int n);
        mode = m; period = CW'(p); high_time = CW'(h); num_pulses = NW'(n);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // monitor for the active-high instance: accumulates the running train, checks on done/cfg_err
    int   bcnt, acnt, runs, mrun, cur;
    bit   prev;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0; acnt = 0; runs = 0; mrun = 0; cur = 0; prev = 0;
        end else begin
            if (!busy) chk("idle_level", 64'(pulse_out), 64'(0));
            if (busy) bcnt++;
            if (pulse_out) begin
                cur++; acnt++;
                if (!prev) runs++;
                if (cur > mrun) mrun = cur;
            end else cur = 0;
            prev = pulse_out;
            if (done || cfg_err) begin
                if (q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_event: done=%0b cfg_err=%0b with nothing expected", done, cfg_err);
                end else begin
                    e = q.pop_front();
                    chk("event_is_err", 64'(cfg_err), 64'(e.err));
                    chk("busy_at_event", 64'(busy), 64'(0));
                    chk("pulse_idx", 64'(pulse_idx), 64'(e.idx));
                    if (!e.err) begin
                        chk("busy_len", 64'(bcnt), 64'(e.busy_len));
                        chk("active_cycles", 64'(acnt), 64'(e.act));
                        chk("pulse_count", 64'(runs), 64'(e.runs));
                        chk("pulse_width", 64'(mrun), 64'(e.max_run));
                    end
                end
                if (done) begin
                    bcnt = 0; acnt = 0; runs = 0; mrun = 0; cur = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (q1.size() != 0) begin
            logic [1:0] v;
            v = q1.pop_front();
            chk("il1_pulse", 64'(pulse_out1), 64'(v[1]));
            chk("il1_busy", 64'(busy1), 64'(v[0]));
        end
    end

    int err_cfg[5][4] = '{'{0, 1, 1, 0}, '{0, 8, 0, 0}, '{1, 8, 8, 4}, '{3, 8, 2, 1}, '{1, 8, 2, 0}};

    initial begin
        cyc(3);
        chk("rst_pulse", 64'(pulse_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_idx", 64'(pulse_idx), 64'(0));
        chk("rst_cfg_err", 64'(cfg_err), 64'(0));
        chk("rst_pulse_il1", 64'(pulse_out1), 64'(1));
        rst = 1'b0;
        cyc(2);
        // burst of 4: 10-cycle period, 3 active
        q.push_back('{1'b0, 40, 12, 4, 3, 4});
        launch(2'd1, 10, 3, 4);
        cyc(44);
        // continuous, stop sampled at cycle 12 -> ends at wrap 15
        q.push_back('{1'b0, 15, 6, 3, 2, 3});
        launch(2'd0, 5, 2, 0);
        cyc(11);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(6);
        // rejected configurations keep pulse_idx at 3
        for (int i = 0; i < 5; i++) begin
            q.push_back('{1'b1, 0, 0, 0, 0, 3});
            launch(2'(err_cfg[i][0]), err_cfg[i][1], err_cfg[i][2], err_cfg[i][3]);
            cyc(2);
        end
        mode = 2'd0; period = 8; high_time = 2;
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        cyc(2);
        chk("start_stop_busy", 64'(busy), 64'(0));
        chk("start_stop_idx", 64'(pulse_idx), 64'(3));
        // single shot with start held: two back-to-back trains
        q.push_back('{1'b0, 4, 1, 1, 1, 1});
        q.push_back('{1'b0, 4, 1, 1, 1, 1});
        mode = 2'd1; mode = 2'd2; period = 4; high_time = 1;
        start = 1'b1;
        cyc(10);
        start = 1'b0;
        cyc(4);
        // reset mid-burst
        launch(2'd1, 4, 2, 3);
        cyc(7);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        chk("pre_rst_idx", 64'(pulse_idx), 64'(1));
        rst = 1'b1;
        cyc(1);
        chk("abort_pulse", 64'(pulse_out), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_idx", 64'(pulse_idx), 64'(0));
        rst = 1'b0;
        cyc(15);
        // config changed during the run has no effect
        q.push_back('{1'b0, 18, 6, 3, 2, 3});
        launch(2'd1, 6, 2, 3);
        cyc(2);
        mode = 2'd0; period = 20; high_time = 10; num_pulses = 9;
        cyc(20);
        // active-low instance: idle high, low 2 of every 6 cycles, two pulses
        mode = 2'd1; period = 6; high_time = 2; num_pulses = 2;
        q1.push_back(2'b10);
        for (int k = 0; k < 12; k++) q1.push_back({(k % 6) >= 2, 1'b1});
        q1.push_back(2'b10);
        q1.push_back(2'b10);
        start1 = 1'b1;
        cyc(1);
        start1 = 1'b0;
        cyc(16);
        chk("il1_idx", 64'(pulse_idx1), 64'(2));
        chk("sb_leftover", 64'(q.size()), 64'(0));
        chk("il1_leftover", 64'(q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
